// File: rtl/m10k_arb_pkg.sv
// m10k_arb_pkg: shared HPS state encoding, read-owner tags and avs register offsets
package m10k_arb_pkg;
    localparam logic [1:0] H_IDLE   = 2'd0;
    localparam logic [1:0] H_WAIT   = 2'd1;
    localparam logic [1:0] H_FLIGHT = 2'd2;
    localparam logic [1:0] H_DONE   = 2'd3;
    localparam logic [1:0] AVS_DATA   = 2'd0;
    localparam logic [1:0] AVS_STATUS = 2'd1;
    localparam logic [1:0] AVS_WAIT   = 2'd2;
    typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_HPS} tag_t;
endpackage

// File: rtl/m10k_read_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: owner-tag delay line tracking which requester each in-flight M10K read belongs to
module rd_tag_pipe
    import m10k_arb_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  tag_t tag_in,
    output tag_t tag_pre,
    output tag_t tag_out
);
    logic [DEPTH-1:0][1:0] pipe;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) pipe <= '0;
        else pipe <= {pipe[DEPTH-2:0], tag_in};
    assign tag_pre = tag_t'(pipe[DEPTH-2]);
    assign tag_out = tag_t'(pipe[DEPTH-1]);
endmodule

// File: rtl/m10k_read_arbiter.sv
// m10k_read_arbiter: shares one M10K read port between a VGA scanout stream and an HPS handshake port
module m10k_read_arbiter
    import m10k_arb_pkg::*;
#(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rdvalid,
    output logic [DATA_W-1:0] vga_rddata,
    input  logic              hps_req,
    input  logic [ADDR_W-1:0] hps_addr,
    output logic              hps_ack,
    output logic [DATA_W-1:0] hps_rddata,
    output logic              mem_rden,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q,
    input  logic [1:0]        avs_address,
    output logic [31:0]       avs_readdata
);
    logic [1:0]        state;
    logic [ADDR_W-1:0] hps_addr_q;
    logic [7:0]        wait_cnt;
    logic [DATA_W-1:0] hps_data_q;
    logic              hps_gnt;
    tag_t              tag_in, tag_pre, tag_out;

    always_comb begin
        hps_gnt     = state == H_WAIT && (!vga_req || wait_cnt >= 8'(MAX_WAIT));
        vga_gnt     = vga_req && !hps_gnt;
        tag_in      = hps_gnt ? TAG_HPS : vga_gnt ? TAG_VGA : TAG_NONE;
        vga_rdvalid = tag_out == TAG_VGA;
        vga_rddata  = vga_rdvalid ? mem_q : '0;
        hps_ack     = state == H_DONE;
        hps_rddata  = tag_out == TAG_HPS ? mem_q : hps_data_q;
    end

    rd_tag_pipe #(.DEPTH(1 + RD_LAT)) u_tags (
        .clk     (clk),
        .reset_n (reset_n),
        .tag_in  (tag_in),
        .tag_pre (tag_pre),
        .tag_out (tag_out)
    );

    // leave H_FLIGHT one cycle early so H_DONE coincides with the data returning
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state        <= H_IDLE;
            hps_addr_q   <= '0;
            wait_cnt     <= '0;
            hps_data_q   <= '0;
            mem_rden     <= 1'b0;
            mem_addr     <= '0;
            avs_readdata <= '0;
        end else begin
            state <= state == H_IDLE   ? (hps_req ? H_WAIT : H_IDLE) :
                     state == H_WAIT   ? (hps_gnt ? H_FLIGHT : H_WAIT) :
                     state == H_FLIGHT ? (tag_pre == TAG_HPS ? H_DONE : H_FLIGHT) :
                                         (hps_req ? H_DONE : H_IDLE);
            if (state == H_IDLE && hps_req) hps_addr_q <= hps_addr;
            wait_cnt <= hps_gnt ? '0 :
                        (state == H_WAIT && wait_cnt != 8'hff) ? wait_cnt + 8'd1 : wait_cnt;
            if (tag_out == TAG_HPS) hps_data_q <= mem_q;
            mem_rden <= hps_gnt || vga_gnt;
            if (hps_gnt || vga_gnt) mem_addr <= hps_gnt ? hps_addr_q : vga_addr;
            avs_readdata <= avs_address == AVS_DATA   ? 32'(hps_rddata) :
                            avs_address == AVS_STATUS ? {30'b0, hps_ack, state != H_IDLE} :
                            avs_address == AVS_WAIT   ? {24'b0, wait_cnt} : 32'd0;
        end
endmodule

// File: tb/tb_m10k_read_arbiter.sv
// tb_m10k_read_arbiter: directed and randomized checks of the arbiter against a transaction-level model
module tb_m10k_read_arbiter;
    localparam int AW = 15, DW = 8, RL = 2, MW = 16;

    logic          clk = 1'b0, reset_n = 1'b0;
    logic          vga_req, vga_gnt, vga_rdvalid, hps_req, hps_ack, mem_rden;
    logic [AW-1:0] vga_addr, hps_addr, mem_addr;
    logic [DW-1:0] vga_rddata, hps_rddata, mem_q;
    logic [1:0]    avs_address;
    logic [31:0]   avs_readdata;

    m10k_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset_n(reset_n),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rdvalid(vga_rdvalid), .vga_rddata(vga_rddata),
        .hps_req(hps_req), .hps_addr(hps_addr), .hps_ack(hps_ack), .hps_rddata(hps_rddata),
        .mem_rden(mem_rden), .mem_addr(mem_addr), .mem_q(mem_q),
        .avs_address(avs_address), .avs_readdata(avs_readdata)
    );

    always #5 clk = ~clk;

    // M10K: data valid RL cycles after the cycle mem_rden is high
    logic [DW-1:0] mem [0:32767];
    logic [DW-1:0] qp  [0:RL-1];
    always @(posedge clk) begin
        qp[0] <= mem_rden ? mem[mem_addr] : 8'($urandom);
        for (int i = 1; i < RL; i++) qp[i] <= qp[i-1];
    end
    assign mem_q = qp[RL-1];

    typedef struct {int at; bit h; logic [7:0] d;} rd_t;
    rd_t pend[$];
    int  cyc, nchk, nfail, waited, t, seen, nv;
    bit  hwait, hfly, hdone, pg, o_ack, o_vgnt, o_vvalid;
    logic [7:0]    hlast, o_vdata, vd;
    logic [AW-1:0] haddr, pa;
    logic [31:0]   avs_exp, o_avs;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        hwait = 0; hfly = 0; hdone = 0; pg = 0;
        waited = 0; hlast = '0; haddr = '0; pa = '0; avs_exp = '0;
    endtask

    task automatic zero_chk();
        chk("rst_vga_gnt", 32'(vga_gnt), 32'(0));
        chk("rst_mem_rden", 32'(mem_rden), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_vga_rdvalid", 32'(vga_rdvalid), 32'(0));
        chk("rst_vga_rddata", 32'(vga_rddata), 32'(0));
        chk("rst_hps_ack", 32'(hps_ack), 32'(0));
        chk("rst_hps_rddata", 32'(hps_rddata), 32'(0));
        chk("rst_avs_readdata", avs_readdata, 32'(0));
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(negedge clk);
        zero_chk();
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    // one clock: check outputs against the model mid-cycle, then advance the model over the edge
    task automatic cycle();
        bit hg, vg, ev, ret, idle;
        logic [7:0] ed, rd;
        rd_t e;
        @(negedge clk);
        hg = hwait && (!vga_req || waited >= MW);
        vg = vga_req && !hg;
        ev = 0; ret = 0; ed = '0; rd = '0;
        while (pend.size() > 0 && pend[0].at == cyc) begin
            e = pend.pop_front();
            if (e.h) begin ret = 1; rd = e.d; end
            else begin ev = 1; ed = e.d; end
        end
        if (ret) begin hfly = 0; hdone = 1; hlast = rd; end
        o_vgnt = vga_gnt; o_ack = hps_ack; o_vvalid = vga_rdvalid; o_vdata = vga_rddata; o_avs = avs_readdata;
        chk("vga_gnt", 32'(vga_gnt), 32'(vg));
        chk("mem_rden", 32'(mem_rden), 32'(pg));
        if (pg) chk("mem_addr", 32'(mem_addr), 32'(pa));
        chk("vga_rdvalid", 32'(vga_rdvalid), 32'(ev));
        chk("vga_rddata", 32'(vga_rddata), 32'(ed));
        chk("hps_ack", 32'(hps_ack), 32'(hdone));
        chk("hps_rddata", 32'(hps_rddata), 32'(hlast));
        chk("avs_readdata", avs_readdata, avs_exp);
        idle = !hwait && !hfly && !hdone;
        avs_exp = avs_address == 2'd0 ? 32'(hlast) :
                  avs_address == 2'd1 ? {30'b0, hdone, !idle} :
                  avs_address == 2'd2 ? 32'(waited) : 32'd0;
        if (hg) begin
            pend.push_back('{cyc + 1 + RL, 1'b1, mem[haddr]});
            hwait = 0; hfly = 1; waited = 0;
        end else if (hwait && waited < 255) waited++;
        if (vg) pend.push_back('{cyc + 1 + RL, 1'b0, mem[vga_addr]});
        pg = hg || vg;
        pa = hg ? haddr : vga_addr;
        if (idle && hps_req) begin hwait = 1; haddr = hps_addr; end
        else if (hdone && !hps_req) hdone = 0;
        cyc++;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 32768; a++) mem[a] = 8'($urandom);
        mem[5] = 8'hA5;
        vga_req = 0; vga_addr = '0; hps_req = 0; hps_addr = '0; avs_address = '0;
        model_reset();
        #2;
        @(negedge clk);
        zero_chk();
        @(posedge clk); #1;
        reset_n = 1'b1;

        // single VGA read of 0x0010
        vga_req = 1; vga_addr = 15'h0010; t = cyc;
        cycle();
        vga_req = 0; seen = -1; vd = '0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (o_vvalid && seen < 0) begin seen = cyc - 1 - t; vd = o_vdata; end
        end
        chk("vga_latency", 32'(seen), 32'(1 + RL));
        chk("vga_data_0x10", 32'(vd), 32'(mem[16]));

        // HPS read of 0x0005 with VGA idle
        hps_req = 1; hps_addr = 15'h0005; t = cyc; seen = -1;
        for (int k = 0; k < 20 && seen < 0; k++) begin
            cycle();
            if (o_ack) seen = cyc - 1 - t;
            hps_addr = 15'($urandom);
        end
        chk("hps_ack_latency", 32'(seen), 32'(4));
        chk("hps_data_0x05", 32'(hps_rddata), 32'h000000A5);
        hps_req = 0;
        cycle();
        cycle();
        chk("hps_ack_drop", 32'(o_ack), 32'(0));

        // avs register reads
        avs_address = 2'd0;
        cycle();
        avs_address = 2'd3;
        cycle();
        chk("avs_hps_data", o_avs, 32'h000000A5);
        avs_address = 2'd1;
        cycle();
        chk("avs_reserved", o_avs, 32'd0);

        // HPS starved by continuous VGA until the wait limit forces a grant
        vga_req = 1; hps_req = 1; hps_addr = 15'($urandom); t = cyc; seen = -1;
        for (int k = 0; k < 40 && seen < 0; k++) begin
            vga_addr = 15'($urandom);
            cycle();
            if (!o_vgnt) seen = cyc - 1 - t;
        end
        chk("hps_forced_gap", 32'(seen), 32'(MW + 1));
        vga_addr = 15'($urandom);
        cycle();
        chk("vga_regrant", 32'(o_vgnt), 32'(1));
        for (int k = 0; k < 20 && !o_ack; k++) begin
            vga_addr = 15'($urandom);
            cycle();
        end
        chk("hps_forced_ack", 32'(o_ack), 32'(1));
        hps_req = 0; vga_req = 0;
        cycle();
        cycle();

        // reset one cycle after a VGA grant kills the in-flight read
        vga_req = 1; vga_addr = 15'($urandom);
        cycle();
        vga_req = 0;
        pulse_reset();
        nv = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            nv += int'(o_vvalid);
        end
        chk("no_rdvalid_after_reset", 32'(nv), 32'(0));

        // randomized traffic with a well-behaved HPS handshake
        for (int k = 0; k < 400; k++) begin
            vga_req = $urandom_range(0, 3) != 0;
            vga_addr = 15'($urandom);
            avs_address = 2'($urandom);
            if (!hps_req) begin
                if (!hwait && !hfly && !hdone && $urandom_range(0, 5) == 0) begin
                    hps_req = 1; hps_addr = 15'($urandom);
                end
            end else if (hdone && $urandom_range(0, 1) == 0) hps_req = 0;
            else hps_addr = 15'($urandom);
            cycle();
        end
        vga_req = 0;
        for (int k = 0; k < 30; k++) begin
            if (hps_req && hdone) hps_req = 0;
            cycle();
        end

        $display("%0d/%0d checks passed", nchk - nfail, nchk);
        $finish;
    end
endmodule
